spike_frame_reader: RTL and testbench



---
 rtl/spike_sram_pkg.sv | 23 ++
 rtl/spk_sync_fifo.sv | 60 ++++++
 rtl/spike_frame_reader.sv | 174 +++++++++++++++++
 tb/tb_spike_frame_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_sram_pkg.sv
// rtl/spike_sram_pkg.sv - shared constants, FSM states and address-wrap helper for the spike SRAM reader
package spike_sram_pkg;

    localparam int DEF_WORD_NUM = 350;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_BIT_W    = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } state_t;

    // Incrementer with a compare against the last valid word, avoiding a modulo.
    function automatic logic [DEF_ADDR_W-1:0] addr_inc(
        input logic [DEF_ADDR_W-1:0] addr,
        input logic [DEF_ADDR_W-1:0] last_addr
    );
        return (addr == last_addr) ? '0 : addr + 1'b1;
    endfunction

endpackage

// File: rtl/spk_sync_fifo.sv
// rtl/spk_sync_fifo.sv - single-clock FIFO with occupancy count; head word is presented combinationally
module spk_sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign do_push  = push && (count_q != (PW+1)'(DEPTH));
    assign do_pop   = pop && (count_q != '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/spike_frame_reader.sv
// rtl/spike_frame_reader.sv - issues wrapped sequential SRAM reads for a frame and streams the spikes out
module spike_frame_reader
    import spike_sram_pkg::*;
#(
    parameter int WORD_NUM   = DEF_WORD_NUM,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BIT_W      = DEF_BIT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] frame_len,
    output logic              busy,
    output logic              done,
    output logic              sram_csb,
    output logic              sram_wsb,
    output logic [ADDR_W-1:0] sram_raddr,
    input  logic [BIT_W-1:0]  sram_rdata,
    output logic              spk_valid,
    input  logic              spk_ready,
    output logic [BIT_W-1:0]  spk_data,
    output logic              spk_last,
    output logic [ADDR_W-1:0] spike_cnt
);

    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_NUM - 1);
    localparam logic [CW:0]       DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              csb_q, csb_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] spike_cnt_q, spike_cnt_d;
    logic              issue_last_q, issue_last_d;
    logic              rvld_q, rvld_d;
    logic              rlast_q, rlast_d;
    logic [1:0]        inflight_q, inflight_d;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [BIT_W:0]    fifo_rdata;
    logic              pop;
    logic [CW:0]       occupancy;
    logic [ADDR_W-1:0] rd_cnt_inc;

    spk_sync_fifo #(
        .WIDTH (BIT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rvld_q),
        .push_data ({rlast_q, sram_rdata}),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign pop        = ~fifo_empty & spk_ready;
    assign occupancy  = {1'b0, fifo_count} + {{(CW-1){1'b0}}, inflight_q};
    assign rd_cnt_inc = rd_cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        csb_d        = 1'b1;
        raddr_d      = raddr_q;
        len_d        = len_q;
        rd_cnt_d     = rd_cnt_q;
        issue_last_d = 1'b0;
        spike_cnt_d  = spike_cnt_q;

        if (pop && (fifo_rdata[BIT_W-1:0] == BIT_W'(1)) && (spike_cnt_q != '1)) begin
            spike_cnt_d = spike_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d       = frame_len;
                    spike_cnt_d = '0;
                    rd_cnt_d    = '0;
                    if (frame_len == '0) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        // First read goes out on the start edge to keep latency at two cycles.
                        state_d      = ST_ISSUE;
                        busy_d       = 1'b1;
                        csb_d        = 1'b0;
                        raddr_d      = base_addr;
                        rd_cnt_d     = ADDR_W'(1);
                        issue_last_d = (frame_len == ADDR_W'(1));
                    end
                end
            end
            ST_ISSUE: begin
                if (rd_cnt_q == len_q) begin
                    state_d = ST_DRAIN;
                end else if (occupancy < DEPTH_LIM) begin
                    csb_d        = 1'b0;
                    raddr_d      = addr_inc(raddr_q, LAST_ADDR);
                    rd_cnt_d     = rd_cnt_inc;
                    issue_last_d = (rd_cnt_inc == len_q);
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_rdata[BIT_W]) begin
                    state_d = ST_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Read data appears one cycle after the issue edge and is pushed on the edge after that.
        rvld_d     = ~csb_q;
        rlast_d    = issue_last_q;
        inflight_d = inflight_q + {1'b0, ~csb_d} - {1'b0, rvld_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            csb_q        <= 1'b1;
            raddr_q      <= '0;
            len_q        <= '0;
            rd_cnt_q     <= '0;
            spike_cnt_q  <= '0;
            issue_last_q <= 1'b0;
            rvld_q       <= 1'b0;
            rlast_q      <= 1'b0;
            inflight_q   <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            csb_q        <= csb_d;
            raddr_q      <= raddr_d;
            len_q        <= len_d;
            rd_cnt_q     <= rd_cnt_d;
            spike_cnt_q  <= spike_cnt_d;
            issue_last_q <= issue_last_d;
            rvld_q       <= rvld_d;
            rlast_q      <= rlast_d;
            inflight_q   <= inflight_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sram_csb   = csb_q;
    assign sram_wsb   = 1'b1;
    assign sram_raddr = raddr_q;
    assign spike_cnt  = spike_cnt_q;
    assign spk_valid  = ~fifo_empty;
    assign spk_data   = fifo_empty ? '0 : fifo_rdata[BIT_W-1:0];
    assign spk_last   = ~fifo_empty & fifo_rdata[BIT_W];

endmodule

// File: tb/tb_spike_frame_reader.sv
// tb/tb_spike_frame_reader.sv - self-checking bench for spike_frame_reader with an SRAM model
module tb_spike_frame_reader;

    localparam int WORD_NUM   = 350;
    localparam int ADDR_W     = 10;
    localparam int BIT_W      = 1;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] frame_len = '0;
    logic              busy, done, sram_csb, sram_wsb;
    logic [ADDR_W-1:0] sram_raddr;
    logic [BIT_W-1:0]  sram_rdata = '0;
    logic              spk_valid;
    logic              spk_ready = 1'b0;
    logic [BIT_W-1:0]  spk_data;
    logic              spk_last;
    logic [ADDR_W-1:0] spike_cnt;

    spike_frame_reader #(
        .WORD_NUM   (WORD_NUM),
        .ADDR_W     (ADDR_W),
        .BIT_W      (BIT_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .frame_len  (frame_len),
        .busy       (busy),
        .done       (done),
        .sram_csb   (sram_csb),
        .sram_wsb   (sram_wsb),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .spk_valid  (spk_valid),
        .spk_ready  (spk_ready),
        .spk_data   (spk_data),
        .spk_last   (spk_last),
        .spike_cnt  (spike_cnt)
    );

    always #5 clk = ~clk;

    bit sram [WORD_NUM];

    always @(posedge clk) begin
        if (!sram_csb && (sram_raddr < WORD_NUM)) begin
            sram_rdata <= BIT_W'(sram[sram_raddr]);
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_csb"},   sram_csb, 1);
        chk({tag, "_wsb"},   sram_wsb, 1);
        chk({tag, "_raddr"}, int'(sram_raddr), 0);
        chk({tag, "_valid"}, spk_valid, 0);
        chk({tag, "_data"},  int'(spk_data), 0);
        chk({tag, "_last"},  spk_last, 0);
        chk({tag, "_cnt"},   int'(spike_cnt), 0);
    endtask

    // mode 0: ready always high; 1: low for 5 cycles then toggling; 2: random ready
    task automatic run_frame(input int base, input int len, input int mode,
                             input int exp_cnt, input int inj_k, input int rst_beat);
        int  exp_d[$];
        int  exp_a[$];
        int  got_a[$];
        int  nb, last_k, prev_data, prev_last, a, lim;
        bit  prev_stall, finished;

        for (int i = 0; i < len; i++) begin
            a = (base + i) % WORD_NUM;
            exp_a.push_back(a);
            exp_d.push_back(int'(sram[a]));
        end
        if (exp_cnt < 0) begin
            exp_cnt = 0;
            foreach (exp_d[i]) exp_cnt += exp_d[i];
        end

        @(negedge clk);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        frame_len = ADDR_W'(len);
        spk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;

        if (len == 0) begin
            chk("zl_done", done, 1);
            chk("zl_csb", sram_csb, 1);
            chk("zl_valid", spk_valid, 0);
            chk("zl_cnt", int'(spike_cnt), 0);
            repeat (3) begin
                @(negedge clk);
                chk("zl_csb_hold", sram_csb, 1);
                chk("zl_valid_hold", spk_valid, 0);
                chk("zl_done_pulse", done, 0);
            end
            return;
        end

        chk("k1_busy", busy, 1);
        chk("k1_csb", sram_csb, 0);
        chk("k1_raddr", int'(sram_raddr), base);

        nb = 0; last_k = -1; finished = 0; prev_stall = 0;
        prev_data = 0; prev_last = 0;
        for (int k = 1; k <= 2000; k++) begin
            if (k > 1) @(negedge clk);
            if (!sram_csb) got_a.push_back(int'(sram_raddr));

            if (nb == len && k == last_k + 1) begin
                chk("done_after_last", done, 1);
                chk("busy_fall", busy, 0);
                chk("spike_cnt", int'(spike_cnt), exp_cnt);
                chk("n_reads", got_a.size(), len);
                for (int i = 0; i < len && i < got_a.size(); i++)
                    chk("raddr_seq", got_a[i], exp_a[i]);
                finished = 1;
                break;
            end

            if (prev_stall) begin
                chk("hold_valid", spk_valid, 1);
                chk("hold_data", int'(spk_data), prev_data);
                chk("hold_last", spk_last, prev_last);
            end

            if (mode == 1 && k == 5) begin
                lim = (len < FIFO_DEPTH) ? len : FIFO_DEPTH;
                chk("bp_issued", got_a.size(), lim);
            end

            case (mode)
                0:       spk_ready = 1'b1;
                1:       spk_ready = (k > 5) && (k % 2 == 0);
                default: spk_ready = ($urandom_range(0, 3) != 0);
            endcase

            if (k == inj_k) begin
                start     = 1'b1;
                base_addr = ADDR_W'(100);
                frame_len = ADDR_W'(3);
            end else begin
                start = 1'b0;
            end

            if (spk_valid && spk_ready) begin
                if (nb == rst_beat) begin
                    #1 rst_n = 1'b0;
                    #1 chk_reset_values("async_rst");
                    start = 1'b0;
                    return;
                end
                if (nb < len) begin
                    chk("beat_data", int'(spk_data), exp_d[nb]);
                    chk("beat_last", spk_last, (nb == len - 1) ? 1 : 0);
                    if (mode == 0) chk("beat_cycle", k, 3 + nb);
                end else begin
                    chk("extra_beat", nb, len - 1);
                end
                nb++;
                if (nb == len) last_k = k;
            end

            prev_stall = spk_valid && !spk_ready;
            prev_data  = int'(spk_data);
            prev_last  = spk_last;
        end
        start = 1'b0;

        if (!finished) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_timeout: got %0d beats, expected %0d", nb, len);
        end else begin
            @(negedge clk);
            chk("done_pulse_end", done, 0);
        end
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        int exp_cnt;
        int inj_k;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int pat[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

        for (int i = 0; i < WORD_NUM; i++) sram[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) sram[i] = 1'(pat[i]);
        sram[348] = 1'b1;
        sram[349] = 1'b1;

        tbl[0] = '{base: 0,   len: 8,  mode: 0, exp_cnt: 4,  inj_k: -1};
        tbl[1] = '{base: 0,   len: 8,  mode: 1, exp_cnt: 4,  inj_k: -1};
        tbl[2] = '{base: 348, len: 4,  mode: 0, exp_cnt: 3,  inj_k: -1};
        tbl[3] = '{base: 0,   len: 0,  mode: 0, exp_cnt: 0,  inj_k: -1};
        tbl[4] = '{base: 0,   len: 8,  mode: 0, exp_cnt: 4,  inj_k: 4};
        tbl[5] = '{base: 345, len: 10, mode: 2, exp_cnt: -1, inj_k: -1};

        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i].base, tbl[i].len, tbl[i].mode, tbl[i].exp_cnt, tbl[i].inj_k, -1);

        run_frame(0, 8, 0, 4, -1, 2);
        @(negedge clk);
        chk_reset_values("rst_held");
        rst_n = 1'b1;
        run_frame(0, 8, 0, 4, -1, -1);

        for (int r = 0; r < 12; r++)
            run_frame(int'($urandom_range(0, WORD_NUM - 1)), int'($urandom_range(0, 30)),
                      int'($urandom_range(0, 2)), -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
